mat_centroid: RTL and testbench



---
 rtl/mat_centroid.sv | 183 ++++++++++++++++++
 tb/tb_mat_centroid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mat_centroid.sv
// Centroid of up to 16 matched feature-point addresses: address -> (x, y) by serial
// restoring division, then mean x/y by two parallel serial dividers. Fixed 141-clock latency.

module mat_centroid_divstep #(
    parameter int W  = 12,
    parameter int DW = 5
) (
    input  logic [W-1:0]  quo,
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] den,
    output logic [W-1:0]  quo_nxt,
    output logic [DW-1:0] rem_nxt
);
    logic [DW:0] trial;
    logic        ge;

    // Dividend bits shift out of the top of quo while quotient bits shift in at the bottom.
    always_comb begin
        trial   = {rem, quo[W-1]};
        ge      = trial >= {1'b0, den};
        rem_nxt = ge ? DW'(trial - {1'b0, den}) : trial[DW-1:0];
        quo_nxt = {quo[W-2:0], ge};
    end
endmodule

module mat_centroid #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int NPTS       = 16,
    parameter int ADDR_W     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPTS*ADDR_W-1:0]   position,
    input  logic                     isMatching,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               centerX,
    output logic [6:0]               centerY,
    output logic [4:0]               pointCount
);
    localparam int QBITS = 7;
    localparam int SUM_W = 12;
    localparam int CNT_W = 5;
    localparam logic [ADDR_W-1:0] NPIX      = ADDR_W'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [2:0]        CONV_LAST = 3'(QBITS);
    localparam logic [3:0]        SLOT_LAST = 4'(NPTS - 1);
    localparam logic [3:0]        DIV_LAST  = 4'(SUM_W - 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, CONVERT, DIVIDE, DONE} state_t;

    state_t                   state;
    logic                     prev_match;
    logic [NPTS*ADDR_W-1:0]   snap;
    logic [SUM_W-1:0]         sum_x;
    // One bit wider than sumY needs, so both dividers run the same 12 steps.
    logic [SUM_W-1:0]         sum_y;
    logic [CNT_W-1:0]         cnt;
    logic [3:0]               slot;
    logic [2:0]               cyc;
    logic [ADDR_W-1:0]        rem;
    logic [QBITS-1:0]         quo;
    logic [3:0]               step;
    logic [CNT_W-1:0]         rem_x, rem_y;

    logic [ADDR_W-1:0]        addr;
    logic [ADDR_W-1:0]        rem_cur;
    logic [ADDR_W-1:0]        dvs;
    logic [2:0]               bit_idx;
    logic                     ge;
    logic                     slot_valid;
    logic [SUM_W-1:0]         qx_nxt, qy_nxt;
    logic [CNT_W-1:0]         rx_nxt, ry_nxt;

    // The slot under conversion always sits at the top of the snapshot, which shifts per slot.
    always_comb begin
        addr       = snap[NPTS*ADDR_W-1 -: ADDR_W];
        rem_cur    = (cyc == 3'd0) ? addr : rem;
        bit_idx    = 3'(QBITS - 1) - cyc;
        dvs        = ADDR_W'(IMG_WIDTH) << bit_idx;
        ge         = rem_cur >= dvs;
        slot_valid = addr < NPIX;
    end

    mat_centroid_divstep #(.W(SUM_W), .DW(CNT_W)) u_div_x (
        .quo     (sum_x),
        .rem     (rem_x),
        .den     (cnt),
        .quo_nxt (qx_nxt),
        .rem_nxt (rx_nxt)
    );

    mat_centroid_divstep #(.W(SUM_W), .DW(CNT_W)) u_div_y (
        .quo     (sum_y),
        .rem     (rem_y),
        .den     (cnt),
        .quo_nxt (qy_nxt),
        .rem_nxt (ry_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_match <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            centerX    <= '0;
            centerY    <= '0;
            pointCount <= '0;
            snap       <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            cnt        <= '0;
            slot       <= '0;
            cyc        <= '0;
            rem        <= '0;
            quo        <= '0;
            step       <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
        end else begin
            prev_match <= isMatching;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (isMatching && !prev_match) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    snap  <= position;
                    sum_x <= '0;
                    sum_y <= '0;
                    cnt   <= '0;
                    slot  <= '0;
                    cyc   <= '0;
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (cyc != CONV_LAST) begin
                        rem <= ge ? rem_cur - dvs : rem_cur;
                        quo <= {quo[QBITS-2:0], ge};
                        cyc <= cyc + 3'd1;
                    end else begin
                        // Invalid slots (incl. the all-ones sentinel) still spend their 8 cycles.
                        if (slot_valid) begin
                            sum_x <= sum_x + {4'b0, rem[7:0]};
                            sum_y <= sum_y + {5'b0, quo};
                            cnt   <= cnt + 5'd1;
                        end
                        snap <= snap << ADDR_W;
                        cyc  <= '0;
                        slot <= slot + 4'd1;
                        if (slot == SLOT_LAST) begin
                            state <= DIVIDE;
                            step  <= '0;
                            rem_x <= '0;
                            rem_y <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    sum_x <= qx_nxt;
                    sum_y <= qy_nxt;
                    rem_x <= rx_nxt;
                    rem_y <= ry_nxt;
                    step  <= step + 4'd1;
                    if (step == DIV_LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        centerX    <= (cnt == '0) ? 8'd0 : qx_nxt[7:0];
                        centerY    <= (cnt == '0) ? 7'd0 : qy_nxt[6:0];
                        pointCount <= cnt;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_centroid.sv
// Directed bench for mat_centroid: fixed latency, averaging, invalid slots, reset abort, dropped starts.

module tb_mat_centroid;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [239:0] position = '0;
    logic         isMatching = 1'b0;
    logic         busy, done;
    logic [7:0]   centerX;
    logic [6:0]   centerY;
    logic [4:0]   pointCount;

    int total = 0;
    int bad   = 0;

    mat_centroid dut (
        .clk        (clk),
        .rst        (rst),
        .position   (position),
        .isMatching (isMatching),
        .busy       (busy),
        .done       (done),
        .centerX    (centerX),
        .centerY    (centerY),
        .pointCount (pointCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [239:0] mk_pos(input logic [14:0] a0, input logic [14:0] a1,
                                            input logic [14:0] rest);
        logic [239:0] p;
        for (int i = 0; i < 16; i++) p[(15-i)*15 +: 15] = rest;
        p[239 -: 15] = a0;
        p[224 -: 15] = a1;
        return p;
    endfunction

    // Returns the edge (counted from the start edge) on which done first appears.
    task automatic wait_done(input int from_e, output int lat, output int gaps, output int chg);
        logic [7:0] cx0;
        logic [6:0] cy0;
        logic [4:0] pc0;
        cx0 = centerX; cy0 = centerY; pc0 = pointCount;
        lat = -1; gaps = 0; chg = 0;
        for (int e = from_e + 1; e <= 300; e++) begin
            tick();
            if (done === 1'b1) begin
                lat = e;
                break;
            end
            if (busy !== 1'b1) gaps++;
            if (centerX !== cx0 || centerY !== cy0 || pointCount !== pc0) chg++;
        end
    endtask

    task automatic start_edge(input string tag);
        isMatching = 1'b1;
        tick();
        chk({tag, "_busy_rise"}, busy, 1);
    endtask

    task automatic finish_run(input string tag, input int from_e,
                              input int ex, input int ey, input int ep);
        int lat, gaps, chg;
        wait_done(from_e, lat, gaps, chg);
        chk({tag, "_latency"}, lat, 141);
        chk({tag, "_busy_gaps"}, gaps, 0);
        chk({tag, "_early_change"}, chg, 0);
        chk({tag, "_centerX"}, centerX, ex);
        chk({tag, "_centerY"}, centerY, ey);
        chk({tag, "_count"}, pointCount, ep);
        chk({tag, "_busy_fall"}, busy, 0);
        isMatching = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_hold_cx"}, centerX, ex);
        tick();
    endtask

    localparam logic [14:0] EMPTY = 15'h7FFF;

    initial begin
        int dcount;
        logic [239:0] alt;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cx", centerX, 0);
        chk("rst_cy", centerY, 0);
        chk("rst_pc", pointCount, 0);
        tick();

        // 1615 = 10*160 + 15
        position = mk_pos(15'd1615, EMPTY, EMPTY);
        start_edge("single");
        finish_run("single", 0, 15, 10, 1);

        position = '0;
        start_edge("zeros");
        finish_run("zeros", 0, 0, 0, 16);

        // (0,0) and (159,119)
        position = mk_pos(15'd0, 15'd19199, EMPTY);
        start_edge("corners");
        finish_run("corners", 0, 79, 59, 2);

        // Reset at edge 50 with isMatching held high; restart on the next edge.
        position = mk_pos(15'd1615, EMPTY, EMPTY);
        start_edge("abort");
        dcount = 0;
        for (int e = 1; e < 50; e++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cx", centerX, 0);
        chk("abort_cy", centerY, 0);
        chk("abort_pc", pointCount, 0);
        tick();
        chk("restart_busy", busy, 1);
        finish_run("restart", 0, 15, 10, 1);

        for (int i = 0; i < 16; i++) alt[(15-i)*15 +: 15] = (i % 2 == 0) ? 15'd19200 : EMPTY;
        position = alt;
        start_edge("invalid");
        finish_run("invalid", 0, 0, 0, 0);

        // A re-trigger at edge 60 with new data must be ignored.
        position = mk_pos(15'd1615, EMPTY, EMPTY);
        start_edge("retrig");
        for (int e = 1; e < 59; e++) tick();
        isMatching = 1'b0;
        position = mk_pos(15'd0, 15'd19199, EMPTY);
        tick();
        isMatching = 1'b1;
        tick();
        chk("retrig_busy60", busy, 1);
        finish_run("retrig", 60, 15, 10, 1);

        start_edge("second");
        finish_run("second", 0, 79, 59, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
